hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the ID/EX register and the stages in front of it.

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/hazard_sat_counter.sv | 27 ++
 rtl/hazard_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   // Sequencer states: normal flow, I-mem redirect shadow, waiting on div/rem.
   typedef enum logic [1:0] {RUN, REDIRECT, MC_WAIT} hz_state_t;

   // x0 is hard-wired zero, so a load targeting it can never create a hazard.
   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall and wait counts.
module hazard_sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // Count up when asked, clear wins over increment, and stick at all-ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for IF, ID and the ID/EX register: load-use hazards,
// taken branch redirects and multi-cycle EX operations (div/rem).
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REDIRECT_CYC = 1,
   parameter int MC_TIMEOUT   = 64,
   parameter int CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_uses_rs1,
   input  logic             i_id_uses_rs2,
   input  logic             i_id_mc_op,
   input  logic [4:0]       i_ex_rd,
   input  logic             i_ex_is_load,
   input  logic             i_ex_reg_write_en,
   input  logic             i_pc_sel,
   input  logic             i_mc_done,
   output logic             o_stall_f,
   output logic             o_stall_d,
   output logic             o_flush_d,
   output logic             o_flush_e,
   output logic             o_mc_start,
   output logic             o_mc_abort,
   output logic             o_mc_err,
   output logic [CNT_W-1:0] o_stall_count
);

   localparam int                TCNT_W     = $clog2(MC_TIMEOUT);
   localparam logic [2:0]        RCNT_LOAD  = 3'(REDIRECT_CYC - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(MC_TIMEOUT - 1);

   hz_state_t         r_state;
   logic [2:0]        r_rcnt;
   logic              r_mcErr;
   logic              w_loadUse;
   logic              w_stallF;
   logic              w_stallD;
   logic              w_flushD;
   logic              w_flushE;
   logic              w_mcStart;
   logic              w_mcAbort;
   logic              w_inWait;
   logic [TCNT_W-1:0] w_tcnt;

   // A load in EX whose destination the ID instruction reads cannot be forwarded in time.
   assign w_loadUse = i_ex_is_load && i_ex_reg_write_en && (i_ex_rd != REG_X0) &&
                      ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

   assign w_inWait = (r_state == MC_WAIT);

   // Output decode: a redirect beats everything; during the redirect shadow ID only
   // holds flushed bubbles and during MC_WAIT EX only holds bubbles, so hazard terms
   // are only evaluated in RUN.
   always_comb begin
      w_stallF  = 1'b0;
      w_stallD  = 1'b0;
      w_flushD  = 1'b0;
      w_flushE  = 1'b0;
      w_mcStart = 1'b0;
      w_mcAbort = 1'b0;
      if (i_pc_sel) begin
         w_flushD  = 1'b1;
         w_flushE  = 1'b1;
         w_mcAbort = w_inWait;
      end else begin
         case (r_state)
            RUN: begin
               if (w_loadUse) begin
                  w_stallF = 1'b1;
                  w_stallD = 1'b1;
                  w_flushE = 1'b1;
               end else if (i_id_mc_op) begin
                  w_mcStart = 1'b1;
                  w_stallF  = 1'b1;
                  w_stallD  = 1'b1;
                  w_flushE  = 1'b1;
               end
            end
            REDIRECT: begin
               w_flushD = 1'b1;
            end
            MC_WAIT: begin
               if (!i_mc_done) begin
                  w_stallF = 1'b1;
                  w_stallD = 1'b1;
                  w_flushE = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sequencer state, redirect shadow counter and the sticky timeout flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RUN;
         r_rcnt  <= 3'd0;
         r_mcErr <= 1'b0;
      end else if (i_pc_sel) begin
         r_rcnt  <= RCNT_LOAD;
         r_state <= (REDIRECT_CYC == 1) ? RUN : REDIRECT;
      end else begin
         case (r_state)
            RUN: begin
               if (!w_loadUse && i_id_mc_op) begin
                  r_state <= MC_WAIT;
               end
            end
            REDIRECT: begin
               r_rcnt <= r_rcnt - 3'd1;
               if (r_rcnt <= 3'd1) begin
                  r_state <= RUN;
               end
            end
            MC_WAIT: begin
               if (i_mc_done) begin
                  r_state <= RUN;
               end else if (w_tcnt == TCNT_LAST) begin
                  r_mcErr <= 1'b1;
               end
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   hazard_sat_counter #(.W(CNT_W)) u_stallCounter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (1'b0),
      .i_inc   (w_stallD),
      .o_count (o_stall_count)
   );

   hazard_sat_counter #(.W(TCNT_W)) u_waitCounter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_mcStart),
      .i_inc   (w_inWait),
      .o_count (w_tcnt)
   );

   assign o_stall_f  = w_stallF;
   assign o_stall_d  = w_stallD;
   assign o_flush_d  = w_flushD;
   assign o_flush_e  = w_flushE;
   assign o_mc_start = w_mcStart;
   assign o_mc_abort = w_mcAbort;
   assign o_mc_err   = r_mcErr;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver applies directed and random
// pipeline events, a reference model pushes the expected outputs, and a monitor
// on the falling edge pops and compares them.
module tb_hazard_stall_ctrl;

   localparam int REDIRECT_CYC = 3;
   localparam int MC_TIMEOUT   = 4;
   localparam int CNT_W        = 6;
   localparam int COUNT_MAX    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [4:0] idRs1;
      logic [4:0] idRs2;
      logic       usesRs1;
      logic       usesRs2;
      logic       idMcOp;
      logic [4:0] exRd;
      logic       exIsLoad;
      logic       exRegWriteEn;
      logic       pcSel;
      logic       mcDone;
   } stim_t;

   typedef struct packed {
      logic             stallF;
      logic             stallD;
      logic             flushD;
      logic             flushE;
      logic             mcStart;
      logic             mcAbort;
      logic             mcErr;
      logic [CNT_W-1:0] stallCount;
   } resp_t;

   logic             clock = 1'b0;
   logic             rstN  = 1'b0;
   logic [4:0]       idRs1 = '0;
   logic [4:0]       idRs2 = '0;
   logic             usesRs1 = 1'b0;
   logic             usesRs2 = 1'b0;
   logic             idMcOp = 1'b0;
   logic [4:0]       exRd = '0;
   logic             exIsLoad = 1'b0;
   logic             exRegWriteEn = 1'b0;
   logic             pcSel = 1'b0;
   logic             mcDone = 1'b0;
   logic             stallF, stallD, flushD, flushE, mcStart, mcAbort, mcErr;
   logic [CNT_W-1:0] stallCount;

   resp_t expQ[$];
   int    checks = 0;
   int    errors = 0;
   int    cycleNo = 0;

   // Reference model: cycles of IF/ID flushing still owed, whether a div/rem is
   // outstanding and for how long, the sticky error and the stall tally.
   int    redirectLeft = 0;
   bit    mcBusy = 1'b0;
   int    mcWaited = 0;
   bit    mcErrM = 1'b0;
   int    stallCountM = 0;

   hazard_stall_ctrl #(
      .REDIRECT_CYC (REDIRECT_CYC),
      .MC_TIMEOUT   (MC_TIMEOUT),
      .CNT_W        (CNT_W)
   ) dut (
      .i_clk             (clock),
      .i_rst_n           (rstN),
      .i_id_rs1          (idRs1),
      .i_id_rs2          (idRs2),
      .i_id_uses_rs1     (usesRs1),
      .i_id_uses_rs2     (usesRs2),
      .i_id_mc_op        (idMcOp),
      .i_ex_rd           (exRd),
      .i_ex_is_load      (exIsLoad),
      .i_ex_reg_write_en (exRegWriteEn),
      .i_pc_sel          (pcSel),
      .i_mc_done         (mcDone),
      .o_stall_f         (stallF),
      .o_stall_d         (stallD),
      .o_flush_d         (flushD),
      .o_flush_e         (flushE),
      .o_mc_start        (mcStart),
      .o_mc_abort        (mcAbort),
      .o_mc_err          (mcErr),
      .o_stall_count     (stallCount)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Compare one observed field against the model and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleNo, actual, expected);
      end
   endtask

   // Advance the reference model by one cycle and return what the DUT should show.
   task automatic modelStep(input stim_t s, output resp_t r);
      bit lu;
      r            = '0;
      r.mcErr      = mcErrM;
      r.stallCount = CNT_W'(stallCountM);
      lu = s.exIsLoad && s.exRegWriteEn && (s.exRd != 5'd0) &&
           ((s.usesRs1 && (s.idRs1 == s.exRd)) || (s.usesRs2 && (s.idRs2 == s.exRd)));
      if (s.pcSel) begin
         r.flushD     = 1'b1;
         r.flushE     = 1'b1;
         r.mcAbort    = mcBusy;
         mcBusy       = 1'b0;
         redirectLeft = REDIRECT_CYC - 1;
      end else if (redirectLeft > 0) begin
         r.flushD = 1'b1;
         redirectLeft--;
      end else if (mcBusy) begin
         if (s.mcDone) begin
            mcBusy = 1'b0;
         end else begin
            r.stallF = 1'b1;
            r.stallD = 1'b1;
            r.flushE = 1'b1;
            mcWaited++;
            if (mcWaited == MC_TIMEOUT) mcErrM = 1'b1;
         end
      end else if (lu) begin
         r.stallF = 1'b1;
         r.stallD = 1'b1;
         r.flushE = 1'b1;
      end else if (s.idMcOp) begin
         r.mcStart = 1'b1;
         r.stallF  = 1'b1;
         r.stallD  = 1'b1;
         r.flushE  = 1'b1;
         mcBusy    = 1'b1;
         mcWaited  = 0;
      end
      if (r.stallD && (stallCountM < COUNT_MAX)) stallCountM++;
   endtask

   // Drive one cycle of inputs just after the rising edge and queue the expectation.
   task automatic applyStimulus(input stim_t s);
      resp_t r;
      @(posedge clock);
      #1;
      rstN         = 1'b1;
      idRs1        = s.idRs1;
      idRs2        = s.idRs2;
      usesRs1      = s.usesRs1;
      usesRs2      = s.usesRs2;
      idMcOp       = s.idMcOp;
      exRd         = s.exRd;
      exIsLoad     = s.exIsLoad;
      exRegWriteEn = s.exRegWriteEn;
      pcSel        = s.pcSel;
      mcDone       = s.mcDone;
      modelStep(s, r);
      expQ.push_back(r);
   endtask

   // Hold reset for some cycles with idle inputs; everything must read zero.
   task automatic applyReset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #1;
         rstN         = 1'b0;
         idRs1        = '0;
         idRs2        = '0;
         usesRs1      = 1'b0;
         usesRs2      = 1'b0;
         idMcOp       = 1'b0;
         exRd         = '0;
         exIsLoad     = 1'b0;
         exRegWriteEn = 1'b0;
         pcSel        = 1'b0;
         mcDone       = 1'b0;
         redirectLeft = 0;
         mcBusy       = 1'b0;
         mcWaited     = 0;
         mcErrM       = 1'b0;
         stallCountM  = 0;
         expQ.push_back('0);
      end
   endtask

   // Monitor: every falling edge with a pending expectation is compared field by field.
   always @(negedge clock) begin : monitor
      resp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("stall_f",     32'(stallF),     32'(e.stallF));
         checkOutput("stall_d",     32'(stallD),     32'(e.stallD));
         checkOutput("flush_d",     32'(flushD),     32'(e.flushD));
         checkOutput("flush_e",     32'(flushE),     32'(e.flushE));
         checkOutput("mc_start",    32'(mcStart),    32'(e.mcStart));
         checkOutput("mc_abort",    32'(mcAbort),    32'(e.mcAbort));
         checkOutput("mc_err",      32'(mcErr),      32'(e.mcErr));
         checkOutput("stall_count", 32'(stallCount), 32'(e.stallCount));
         cycleNo++;
      end
   end

   // Stimulus: directed scenarios first, then randomized pipeline traffic.
   initial begin : driver
      stim_t s;
      stim_t idle;
      idle = '0;

      applyReset(3);
      repeat (3) applyStimulus(idle);

      // Load-use on rs1, then the load has left EX.
      s = idle; s.exIsLoad = 1'b1; s.exRegWriteEn = 1'b1; s.exRd = 5'd5;
      s.idRs1 = 5'd5; s.usesRs1 = 1'b1;
      applyStimulus(s);
      applyStimulus(idle);

      // Load to x0, load without write enable, unused operand: no stall. rs2 hit: stall.
      s = idle; s.exIsLoad = 1'b1; s.exRegWriteEn = 1'b1; s.exRd = 5'd0; s.usesRs1 = 1'b1;
      applyStimulus(s);
      s = idle; s.exIsLoad = 1'b1; s.exRd = 5'd5; s.idRs1 = 5'd5; s.usesRs1 = 1'b1;
      applyStimulus(s);
      s = idle; s.exIsLoad = 1'b1; s.exRegWriteEn = 1'b1; s.exRd = 5'd9; s.idRs2 = 5'd9;
      applyStimulus(s);
      s.usesRs2 = 1'b1;
      applyStimulus(s);

      // Redirect pulse: FLUSH_E once, FLUSH_D for three cycles.
      s = idle; s.pcSel = 1'b1;
      applyStimulus(s);
      repeat (4) applyStimulus(idle);

      // Multi-cycle op completing ten cycles after launch.
      applyReset(1);
      s = idle; s.idMcOp = 1'b1;
      repeat (10) applyStimulus(s);
      s.mcDone = 1'b1;
      applyStimulus(s);
      repeat (2) applyStimulus(idle);

      // Redirect and completion together while waiting: abort wins.
      applyReset(1);
      s = idle; s.idMcOp = 1'b1;
      repeat (3) applyStimulus(s);
      s.pcSel = 1'b1; s.mcDone = 1'b1;
      applyStimulus(s);
      repeat (3) applyStimulus(idle);

      // Timeout without completion, then asynchronous reset mid-wait.
      applyReset(1);
      s = idle; s.idMcOp = 1'b1;
      repeat (7) applyStimulus(s);
      applyReset(2);
      repeat (2) applyStimulus(idle);

      // Long load-use run saturates the stall counter; stray MC_DONE is ignored.
      s = idle; s.exIsLoad = 1'b1; s.exRegWriteEn = 1'b1; s.exRd = 5'd3;
      s.idRs1 = 5'd3; s.usesRs1 = 1'b1;
      repeat (70) applyStimulus(s);
      s = idle; s.mcDone = 1'b1;
      repeat (2) applyStimulus(s);

      // Random traffic: ID holds bubbles during redirect, EX holds bubbles while waiting.
      applyReset(1);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            applyReset(1);
         end else begin
            s.pcSel        = ($urandom_range(0, 11) == 0);
            s.exRd         = 5'($urandom_range(0, 3));
            s.idRs1        = 5'($urandom_range(0, 3));
            s.idRs2        = 5'($urandom_range(0, 3));
            s.usesRs1      = 1'($urandom_range(0, 1));
            s.usesRs2      = 1'($urandom_range(0, 1));
            s.exIsLoad     = mcBusy ? 1'b0 : 1'($urandom_range(0, 1));
            s.exRegWriteEn = ($urandom_range(0, 3) != 0);
            s.idMcOp       = mcBusy ? 1'b1 : ($urandom_range(0, 7) == 0);
            s.mcDone       = mcBusy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            if (redirectLeft > 0) begin
               s.usesRs1 = 1'b0;
               s.usesRs2 = 1'b0;
               s.idMcOp  = 1'b0;
            end
            applyStimulus(s);
         end
      end

      repeat (2) @(negedge clock);
      checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stalled run.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
